// File: rtl/prio_scan_pkg.sv
// Shared types, constants and elaboration helpers for the priority-encoder display path.
package prio_scan_pkg;

    // Converter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } conv_state_t;

    // 7-segment patterns {dp,g,f,e,d,c,b,a}; entry n lights hex digit n
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_ALL   = 8'hFF;

    // Ceiling log2, never below 1 so it can size a vector directly
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

    // Number of decimal digits needed to print v
    function automatic int unsigned dec_digits(input int unsigned v);
        int unsigned n;
        int unsigned x;
        n = 1;
        x = v;
        while (x >= 10) begin
            x = x / 10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per CONV cycle, hex mode bypasses straight to LOAD.
module bin2bcd_seq
    import prio_scan_pkg::*;
#(
    parameter int unsigned IW = 4,
    parameter int unsigned ND = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hex,
    input  logic [IW-1:0]     bin,
    output logic              idle_c,
    output logic              done_c,
    output logic [4*ND-1:0]   bcd
);

    localparam int unsigned BW = 4 * ND;
    localparam int unsigned CW = clog2(IW);

    conv_state_t   state;
    conv_state_t   state_nx;
    logic [BW-1:0] sr_bcd;
    logic [IW-1:0] sr_bin;
    logic [CW-1:0] cnt;
    logic [BW-1:0] adj_c;
    logic          last_shift_c;

    assign last_shift_c = (cnt == CW'(IW - 1));
    assign bcd          = sr_bcd;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and status decode
    always_comb begin
        state_nx = state;
        idle_c   = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE: begin
                idle_c = 1'b1;
                if (start) state_nx = hex ? LOAD : CONV;
            end
            CONV: begin
                if (last_shift_c) state_nx = LOAD;
            end
            LOAD: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble that is 5 or more
    always_comb begin
        adj_c = sr_bcd;
        for (int k = 0; k < int'(ND); k++) begin
            if (sr_bcd[k*4 +: 4] >= 4'd5) adj_c[k*4 +: 4] = sr_bcd[k*4 +: 4] + 4'd3;
        end
    end

    // Shift register and shift counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_bcd <= '0;
            sr_bin <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        sr_bin <= bin;
                        sr_bcd <= hex ? BW'(bin) : '0;
                    end
                end
                CONV: begin
                    sr_bcd <= {adj_c[BW-2:0], sr_bin[IW-1]};
                    sr_bin <= sr_bin << 1;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/prio_enc_scan_disp.sv
// Active-low priority encoder with 74HC148-style flags, BCD/hex conversion and a
// multiplexed common-cathode 7-segment scanner.
// Optional: define PRIO_SCAN_LZB_EN for leading-zero blanking.
module prio_enc_scan_disp
    import prio_scan_pkg::*;
#(
    parameter int unsigned N_IN     = 16,
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ei_n,
    input  logic [N_IN-1:0]          in_n,
    input  logic                     le,
    input  logic                     hex_mode,
    input  logic                     lt_n,
    input  logic                     bi_n,
    output logic [clog2(N_IN)-1:0]   code,
    output logic                     gs_n,
    output logic                     eo_n,
    output logic [7:0]               seg,
    output logic [DIGITS-1:0]        dig_n
);

    localparam int unsigned IW     = clog2(N_IN);
    localparam int unsigned BW     = 4 * DIGITS;
    localparam int unsigned SW     = clog2(DIGITS);
    localparam int unsigned PW     = clog2(SCAN_DIV);
    localparam int unsigned SNAP_W = IW + 2;

    logic              hit_c;
    logic [IW-1:0]     idx_c;
    logic [SNAP_W-1:0] snap_c;
    logic [SNAP_W-1:0] last_snap;
    logic              start_c;
    logic              idle_c;
    logic              done_c;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     disp_buf;
    logic              buf_gs_n;
    logic [PW-1:0]     presc;
    logic [SW-1:0]     scan_idx;
    logic [3:0]        nib_c;
    logic              blank_c;
    logic [7:0]        seg_c;

    // Highest-numbered active-low request wins
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (!in_n[i]) begin
                hit_c = 1'b1;
                idx_c = IW'(i);
            end
        end
    end

    // Capture register; le freezes code and both flags
    always_ff @(posedge clk) begin
        if (rst) begin
            code <= '0;
            gs_n <= 1'b1;
            eo_n <= 1'b1;
        end else if (!le) begin
            if (ei_n) begin
                code <= '0;
                gs_n <= 1'b1;
                eo_n <= 1'b1;
            end else if (hit_c) begin
                code <= idx_c;
                gs_n <= 1'b0;
                eo_n <= 1'b1;
            end else begin
                code <= '0;
                gs_n <= 1'b1;
                eo_n <= 1'b0;
            end
        end
    end

    assign snap_c  = {code, gs_n, hex_mode};
    assign start_c = idle_c && (snap_c != last_snap);

    // Last converted snapshot; cleared on reset so the first compare always converts
    always_ff @(posedge clk) begin
        if (rst)          last_snap <= '0;
        else if (start_c) last_snap <= snap_c;
    end

    bin2bcd_seq #(
        .IW (IW),
        .ND (DIGITS)
    ) u_conv (
        .clk    (clk),
        .rst    (rst),
        .start  (start_c),
        .hex    (hex_mode),
        .bin    (code),
        .idle_c (idle_c),
        .done_c (done_c),
        .bcd    (bcd)
    );

    // Display buffer, updated only when a conversion completes
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_buf <= '0;
            buf_gs_n <= 1'b1;
        end else if (done_c) begin
            disp_buf <= bcd;
            buf_gs_n <= last_snap[1];
        end
    end

    // Prescaler and digit scan index
    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            scan_idx <= '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc    <= '0;
            scan_idx <= (scan_idx == SW'(DIGITS - 1)) ? '0 : scan_idx + SW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign nib_c = disp_buf[{scan_idx, 2'b00} +: 4];

    // Leading-zero detection for the digit being scanned
    always_comb begin
        blank_c = 1'b0;
`ifdef PRIO_SCAN_LZB_EN
        blank_c = (scan_idx != '0);
        for (int j = 0; j < int'(DIGITS); j++) begin
            if ((j >= int'(scan_idx)) && (disp_buf[j*4 +: 4] != 4'd0)) blank_c = 1'b0;
        end
`endif
    end

    // Segment override priority: lamp test, then blanking, then lookup
    always_comb begin
        seg_c = SEG_LUT[nib_c];
        if (!lt_n)                            seg_c = SEG_ALL;
        else if (!bi_n || buf_gs_n || blank_c) seg_c = SEG_BLANK;
    end

    // Registered segment bus and digit select
    always_ff @(posedge clk) begin
        if (rst) begin
            seg   <= SEG_BLANK;
            dig_n <= '1;
        end else begin
            seg   <= seg_c;
            dig_n <= ~(DIGITS'(1) << scan_idx);
        end
    end

endmodule

// File: tb/tb_prio_enc_scan_disp.sv
// Self-checking bench for prio_enc_scan_disp (N_IN=16, DIGITS=2, SCAN_DIV=4).
module tb_prio_enc_scan_disp;

    localparam int N_IN     = 16;
    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ei_n = 1'b1;
    logic [15:0] in_n = '1;
    logic        le = 1'b0;
    logic        hex_mode = 1'b0;
    logic        lt_n = 1'b1;
    logic        bi_n = 1'b1;
    logic [3:0]  code;
    logic        gs_n;
    logic        eo_n;
    logic [7:0]  seg;
    logic [1:0]  dig_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prio_enc_scan_disp #(
        .N_IN     (N_IN),
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ei_n     (ei_n),
        .in_n     (in_n),
        .le       (le),
        .hex_mode (hex_mode),
        .lt_n     (lt_n),
        .bi_n     (bi_n),
        .code     (code),
        .gs_n     (gs_n),
        .eo_n     (eo_n),
        .seg      (seg),
        .dig_n    (dig_n)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Highest index with a low request, -1 if none
    function automatic int model_idx(input logic [15:0] v_n);
        for (int i = 15; i >= 0; i--) if (!v_n[i]) return i;
        return -1;
    endfunction

    // Expected pattern for display position pos when showing value
    function automatic logic [7:0] model_seg(input int pos, input int value, input bit hex,
                                             input bit gsn, input bit lt, input bit bi);
        int lut [16];
        int base;
        int d;
        lut  = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                 'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
        base = hex ? 16 : 10;
        d    = (value / (base ** pos)) % base;
        if (!lt)       return 8'hFF;
        if (!bi || gsn) return 8'h00;
`ifdef PRIO_SCAN_LZB_EN
        if (pos > 0 && value < base ** pos) return 8'h00;
`endif
        return 8'(lut[d]);
    endfunction

    // Watch one full scan and compare each digit's segments with the model
    task automatic check_display(input string tag, input int value, input bit hex,
                                 input bit gsn, input bit lt, input bit bi);
        logic [7:0] got [2];
        bit         seen [2];
        got  = '{8'h00, 8'h00};
        seen = '{1'b0, 1'b0};
        for (int c = 0; c < 2 * SCAN_DIV + 2; c++) begin
            if (dig_n == 2'b10) begin got[0] = seg; seen[0] = 1'b1; end
            else if (dig_n == 2'b01) begin got[1] = seg; seen[1] = 1'b1; end
            tick(1);
        end
        for (int p = 0; p < 2; p++) begin
            check($sformatf("%s d%0d seen", tag, p), 32'(seen[p]), 32'd1);
            check($sformatf("%s d%0d seg", tag, p), 32'(got[p]),
                  32'(model_seg(p, value, hex, gsn, lt, bi)));
        end
    endtask

    initial begin
        logic [1:0] prev;
        int         t;
        int         pos;

        // Reset state
        tick(3);
        check("rst code", 32'(code), 32'd0);
        check("rst gs_n", 32'(gs_n), 32'd1);
        check("rst eo_n", 32'(eo_n), 32'd1);
        check("rst seg", 32'(seg), 32'h00);
        check("rst dig_n", 32'(dig_n), 32'b11);

        // Start a decimal conversion, then reset in the middle of it
        rst  = 1'b0;
        ei_n = 1'b0;
        in_n = ~((16'd1 << 13) | (16'd1 << 2));
        tick(3);
        rst = 1'b1;
        tick(1);
        check("midconv rst seg", 32'(seg), 32'h00);
        check("midconv rst dig_n", 32'(dig_n), 32'b11);
        check("midconv rst code", 32'(code), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("release dig_n", 32'(dig_n), 32'b10);
        check("release seg", 32'(seg), 32'h00);

        // Decimal 13
        check("dec13 code", 32'(code), 32'd13);
        check("dec13 gs_n", 32'(gs_n), 32'd0);
        check("dec13 eo_n", 32'(eo_n), 32'd1);
        tick(8);
        check_display("dec13", 13, 1'b0, 1'b0, 1'b1, 1'b1);

        // Scan period
        prev = dig_n;
        t = 0;
        while (dig_n == prev && t < 12) begin tick(1); t++; end
        prev = dig_n;
        t = 0;
        do begin tick(1); t++; end while (dig_n == prev && t < 12);
        check("scan period", 32'(t), 32'(SCAN_DIV));

        // Hex 13
        hex_mode = 1'b1;
        tick(6);
        check_display("hex13", 13, 1'b1, 1'b0, 1'b1, 1'b1);

        // No request, then encoder disabled
        hex_mode = 1'b0;
        in_n     = '1;
        tick(1);
        check("none code", 32'(code), 32'd0);
        check("none gs_n", 32'(gs_n), 32'd1);
        check("none eo_n", 32'(eo_n), 32'd0);
        tick(8);
        check_display("none", 0, 1'b0, 1'b1, 1'b1, 1'b1);
        ei_n = 1'b1;
        tick(1);
        check("dis gs_n", 32'(gs_n), 32'd1);
        check("dis eo_n", 32'(eo_n), 32'd1);

        // Latch holds code 9 against a higher request
        ei_n = 1'b0;
        in_n = ~(16'd1 << 9);
        tick(1);
        check("cap9 code", 32'(code), 32'd9);
        le   = 1'b1;
        in_n = ~(16'd1 << 15);
        tick(2);
        check("hold code", 32'(code), 32'd9);
        check("hold gs_n", 32'(gs_n), 32'd0);
        tick(8);
        check_display("hold9", 9, 1'b0, 1'b0, 1'b1, 1'b1);

        // Lamp test beats blanking; blanking alone clears segments
        lt_n = 1'b0;
        bi_n = 1'b0;
        tick(1);
        check_display("lamp", 9, 1'b0, 1'b0, 1'b0, 1'b0);
        lt_n = 1'b1;
        tick(1);
        check_display("blank", 9, 1'b0, 1'b0, 1'b1, 1'b0);
        bi_n = 1'b1;

        // Code changes during CONV: old value stays up until LOAD, then final value
        le   = 1'b0;
        in_n = ~(16'd1 << 12);
        tick(1);
        check("chg12 code", 32'(code), 32'd12);
        tick(2);
        in_n = ~(16'd1 << 7);
        tick(1);
        check("chg7 code", 32'(code), 32'd7);
        for (int k = 0; k < 3; k++) begin
            pos = (dig_n == 2'b10) ? 0 : 1;
            check($sformatf("old buf e%0d", k + 3), 32'(seg),
                  32'(model_seg(pos, 9, 1'b0, 1'b0, 1'b1, 1'b1)));
            tick(1);
        end
        tick(20);
        check_display("reconv7", 7, 1'b0, 1'b0, 1'b1, 1'b1);

        // Randomized traffic against the reference model
        for (int r = 0; r < 24; r++) begin
            int  idx;
            int  exp_code;
            bit  exp_gs;
            bit  exp_eo;
            in_n     = 16'($urandom);
            if ($urandom_range(0, 3) == 0) in_n = '1;
            ei_n     = ($urandom_range(0, 3) == 0);
            hex_mode = 1'($urandom_range(0, 1));
            lt_n     = ($urandom_range(0, 5) != 0);
            bi_n     = ($urandom_range(0, 5) != 0);
            idx      = model_idx(in_n);
            if (ei_n)          begin exp_code = 0;   exp_gs = 1'b1; exp_eo = 1'b1; end
            else if (idx >= 0) begin exp_code = idx; exp_gs = 1'b0; exp_eo = 1'b1; end
            else               begin exp_code = 0;   exp_gs = 1'b1; exp_eo = 1'b0; end
            tick(1);
            check($sformatf("rnd%0d code", r), 32'(code), 32'(exp_code));
            check($sformatf("rnd%0d gs_n", r), 32'(gs_n), 32'(exp_gs));
            check($sformatf("rnd%0d eo_n", r), 32'(eo_n), 32'(exp_eo));
            tick(9);
            check_display($sformatf("rnd%0d", r), exp_code, hex_mode, exp_gs, lt_n, bi_n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
